// File: rtl/piso_tx.sv
// piso_tx: parallel-in, serial-out transmitter.
//
// Takes a WIDTH-bit word over a valid/ready handshake and sends it one bit
// per consumed serial cycle on ser_out. The final bit of each word is
// flagged on ser_last. A new word can be taken in the cycle that the final
// bit is consumed, so words can follow each other with no idle cycle.
//
// Parameters
//   WIDTH      bits per word (2..32)
//   MSB_FIRST  1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
//
// Ports
//   clock       system clock, rising edge
//   reset_n     asynchronous active-low reset
//   load_valid  upstream offers load_data
//   load_ready  a word can be accepted this cycle
//   load_data   parallel word to transmit
//   ser_ready   receiver consumes the current serial bit this cycle
//   ser_out     current serial data bit (0 when idle)
//   ser_valid   ser_out holds a valid bit
//   ser_last    current bit is the final bit of the word
//   busy        a word is in flight (same as ser_valid)
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [CW-1:0]    cnt_reg, cnt_next;

  logic active;
  logic last_bit;
  logic accept;
  logic [WIDTH-1:0] shreg_shifted;

  assign active   = (state_reg == SHIFT);
  assign last_bit = active && (cnt_reg == LAST_IDX);

  // Ready when idle, or when the final bit is being consumed right now so
  // the next word follows without a gap.
  assign load_ready = !active || (last_bit && ser_ready);
  assign accept     = load_valid && load_ready;

  // Move the next bit toward the output end, zero-filling behind it.
  generate
    if (MSB_FIRST) begin : g_msb
      assign shreg_shifted = {shreg_reg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign shreg_shifted = {1'b0, shreg_reg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      shreg_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      shreg_reg <= shreg_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    cnt_next   = cnt_reg;
    if (accept) begin
      // A load takes priority, including over the final-bit consume.
      state_next = SHIFT;
      shreg_next = load_data;
      cnt_next   = '0;
    end else if (active && ser_ready) begin
      if (cnt_reg == LAST_IDX) begin
        state_next = IDLE;
      end else begin
        cnt_next   = cnt_reg + 1'b1;
        shreg_next = shreg_shifted;
      end
    end
  end

  generate
    if (MSB_FIRST) begin : g_out_msb
      assign ser_out = active ? shreg_reg[WIDTH-1] : 1'b0;
    end else begin : g_out_lsb
      assign ser_out = active ? shreg_reg[0] : 1'b0;
    end
  endgenerate

  assign ser_valid = active;
  assign busy      = active;
  assign ser_last  = last_bit;

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: randomized self-checking bench for piso_tx.
//
// Two instances share the same stimulus: one built MSB-first and one built
// LSB-first. A reference model tracks the word in flight and the position
// of the current bit within it, and predicts every output each cycle. A
// word scoreboard also rebuilds each received word from the consumed bits
// and compares it with the word that was accepted.
module tb_piso_tx;

  localparam int W = 8;

  logic         clock;
  logic         reset_n;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         ser_ready;

  logic m_load_ready, m_ser_out, m_ser_valid, m_ser_last, m_busy;
  logic l_load_ready, l_ser_out, l_ser_valid, l_ser_last, l_busy;

  int checks;
  int failures;

  // reference model state
  bit           ref_active;
  logic [W-1:0] ref_word;
  int           ref_pos;
  logic [W-1:0] word_q[$];
  logic [W-1:0] rx_msb;
  logic [W-1:0] rx_lsb;

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_valid (load_valid),
    .load_ready (m_load_ready),
    .load_data  (load_data),
    .ser_ready  (ser_ready),
    .ser_out    (m_ser_out),
    .ser_valid  (m_ser_valid),
    .ser_last   (m_ser_last),
    .busy       (m_busy)
  );

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_valid (load_valid),
    .load_ready (l_load_ready),
    .load_data  (load_data),
    .ser_ready  (ser_ready),
    .ser_out    (l_ser_out),
    .ser_valid  (l_ser_valid),
    .ser_last   (l_ser_last),
    .busy       (l_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ref_active = 1'b0;
    ref_word   = '0;
    ref_pos    = 0;
    rx_msb     = '0;
    rx_lsb     = '0;
    word_q.delete();
  endtask

  // One clock cycle: drive inputs just after a falling edge, check all
  // outputs against the model, advance the model, wait for the next
  // falling edge (the rising edge happens in between).
  task automatic cycle(input logic lv, input logic [W-1:0] ld, input logic sr);
    logic exp_ready, exp_last, exp_msb_bit, exp_lsb_bit;
    load_valid = lv;
    load_data  = ld;
    ser_ready  = sr;
    #1;
    exp_ready   = !ref_active || ((ref_pos == W-1) && sr);
    exp_last    = ref_active && (ref_pos == W-1);
    exp_msb_bit = ref_active ? ref_word[W-1-ref_pos] : 1'b0;
    exp_lsb_bit = ref_active ? ref_word[ref_pos]     : 1'b0;

    check("msb_ready", 32'(m_load_ready), 32'(exp_ready));
    check("msb_valid", 32'(m_ser_valid),  32'(ref_active));
    check("msb_busy",  32'(m_busy),       32'(ref_active));
    check("msb_last",  32'(m_ser_last),   32'(exp_last));
    check("msb_out",   32'(m_ser_out),    32'(exp_msb_bit));
    check("lsb_ready", 32'(l_load_ready), 32'(exp_ready));
    check("lsb_valid", 32'(l_ser_valid),  32'(ref_active));
    check("lsb_last",  32'(l_ser_last),   32'(exp_last));
    check("lsb_out",   32'(l_ser_out),    32'(exp_lsb_bit));

    // word scoreboard: collect what the DUTs actually put on the line
    if (ref_active && sr) begin
      rx_msb = {rx_msb[W-2:0], m_ser_out};
      rx_lsb[ref_pos] = l_ser_out;
      if (ref_pos == W-1) begin
        if (word_q.size() == 0) begin
          check("word_queue_empty", 32'd1, 32'd0);
        end else begin
          logic [W-1:0] exp_word;
          exp_word = word_q.pop_front();
          check("msb_word", 32'(rx_msb), 32'(exp_word));
          check("lsb_word", 32'(rx_lsb), 32'(exp_word));
          $display("word sent: expected=%02h msb_rx=%02h lsb_rx=%02h", exp_word, rx_msb, rx_lsb);
        end
        rx_msb = '0;
        rx_lsb = '0;
      end
    end

    // advance the model
    if (lv && exp_ready) begin
      ref_active = 1'b1;
      ref_word   = ld;
      ref_pos    = 0;
      word_q.push_back(ld);
    end else if (ref_active && sr) begin
      if (ref_pos == W-1) ref_active = 1'b0;
      else ref_pos++;
    end
    @(negedge clock);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    load_valid = 1'b0;
    load_data  = '0;
    ser_ready  = 1'b0;
    reset_n    = 1'b0;
    model_reset();

    // reset and idle
    repeat (2) @(negedge clock);
    #1;
    check("rst_valid", 32'(m_ser_valid), 32'd0);
    check("rst_out",   32'(m_ser_out),   32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    repeat (3) cycle(1'b0, '0, 1'b1);

    // single word, ser_ready held high
    cycle(1'b1, 8'hA5, 1'b1);
    repeat (W + 1) cycle(1'b0, '0, 1'b1);

    // back-to-back: load_valid held high with the second word
    cycle(1'b1, 8'hA5, 1'b1);
    repeat (W) cycle(1'b1, 8'h3C, 1'b1);
    repeat (W + 1) cycle(1'b0, '0, 1'b1);

    // stall three cycles on bit index 2
    cycle(1'b1, 8'hA5, 1'b1);
    repeat (2) cycle(1'b0, '0, 1'b1);
    repeat (3) cycle(1'b0, '0, 1'b0);
    repeat (W) cycle(1'b0, '0, 1'b1);

    // busy rejection: 8'hFF offered while 8'h01 is shifting
    cycle(1'b1, 8'h01, 1'b1);
    repeat (W) cycle(1'b1, 8'hFF, 1'b1);
    repeat (W + 1) cycle(1'b0, '0, 1'b1);

    // reset mid-word at bit index 4
    cycle(1'b1, 8'hA5, 1'b1);
    repeat (4) cycle(1'b0, '0, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_msb_valid", 32'(m_ser_valid), 32'd0);
    check("async_rst_msb_out",   32'(m_ser_out),   32'd0);
    check("async_rst_lsb_valid", 32'(l_ser_valid), 32'd0);
    check("async_rst_ready",     32'(m_load_ready), 32'd1);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    repeat (W + 2) cycle(1'b0, '0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 9) < 7));
    end

    // drain and confirm every accepted word came out
    repeat (W + 2) cycle(1'b0, '0, 1'b1);
    check("drain_queue", 32'(word_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
